// File: rtl/mealy_seq_arb.sv
// mealy_seq_arb
// Round-robin arbiter that runs one job at a time through a shared
// external Mealy FSM. The FSM is held in reset before each job. Each job
// symbol is then driven onto the FSM inputs, one symbol per cycle. The
// FSM's combinational outputs are captured into a result word.
//
// Parameters
//   CLR_CYCLES     cycles (1..4) that fsm_rst_b is held low before each job
//
// Ports
//   clk            clock; all state updates on its rising edge
//   rst_b          asynchronous active-low reset
//   req0/req1      job requests, held high until the matching grant
//   cmd0/cmd1      four 2-bit symbols, symbol k = cmd[2k+1:2k] = {a,b}
//   len0/len1      number of symbols minus 1
//   gnt0/gnt1      one-cycle grant pulse; cmd/len captured in that cycle
//   fsm_a/fsm_b    drive the shared FSM's a and b inputs
//   fsm_m/fsm_n    the shared FSM's combinational Mealy outputs
//   fsm_rst_b      active-low reset to the shared FSM
//   res            captured {m,n} per symbol, pair k at res[2k+1:2k]
//   res_id         requester that owns res
//   done           one-cycle pulse: res/res_id newly valid
//   busy           high in every state except IDLE
module mealy_seq_arb #(
    parameter int CLR_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] cmd0,
    input  logic [7:0] cmd1,
    input  logic [1:0] len0,
    input  logic [1:0] len1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       fsm_a,
    output logic       fsm_b,
    input  logic       fsm_m,
    input  logic       fsm_n,
    output logic       fsm_rst_b,
    output logic [7:0] res,
    output logic       res_id,
    output logic       done,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0111,
        CLEAR = 4'b1011,
        RUN   = 4'b1101,
        DONE  = 4'b1110
    } state_t;

    localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

    state_t     state;
    logic       armed;      // low only until the first edge after reset
    logic       prio;       // requester that wins a tie (0 after reset)
    logic [1:0] cnt;        // CLEAR cycle count, then RUN symbol index
    logic [7:0] job_cmd;
    logic [1:0] job_len;
    logic       job_id;
    logic [7:0] acc;        // result pairs collected so far in RUN

    logic       grant;
    logic       pick;
    logic [1:0] sym;
    logic [7:0] acc_next;

    // Grant and FSM-interface decode. The armed flag blocks a grant in
    // the first cycle after reset. It also keeps the shared FSM in reset
    // until the first clock edge.
    always_comb begin
        grant     = armed && (state == IDLE) && (req0 || req1);
        // A lone request always wins; on a tie the priority flag decides.
        pick      = (req0 && req1) ? prio : req1;
        gnt0      = grant && !pick;
        gnt1      = grant && pick;
        sym       = job_cmd[{cnt, 1'b0} +: 2];
        fsm_a     = (state == RUN) && sym[1];
        fsm_b     = (state == RUN) && sym[0];
        fsm_rst_b = armed && (state != CLEAR);
        busy      = (state != IDLE);
        done      = (state == DONE);
        acc_next  = acc;
        acc_next[{cnt, 1'b0} +: 2] = {fsm_m, fsm_n};
    end

    // Controller FSM. res is loaded directly from the final pair on the
    // last RUN edge, so res is already valid while DONE is shown.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            armed   <= 1'b0;
            prio    <= 1'b0;
            cnt     <= 2'd0;
            job_cmd <= 8'h00;
            job_len <= 2'd0;
            job_id  <= 1'b0;
            acc     <= 8'h00;
            res     <= 8'h00;
            res_id  <= 1'b0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        job_cmd <= pick ? cmd1 : cmd0;
                        job_len <= pick ? len1 : len0;
                        job_id  <= pick;
                        prio    <= ~pick;
                        acc     <= 8'h00;
                        cnt     <= 2'd0;
                        state   <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        cnt   <= 2'd0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (cnt == job_len) begin
                        res    <= acc_next;
                        res_id <= job_id;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mealy_seq_arb.md
MEALY_SEQ_ARB -- requirements
Module: mealy_seq_arb

Interface
REQ-001 The block SHALL have one parameter: CLR_CYCLES, default 1, the number of cycles (1..4) that fsm_rst_b is held low before each job.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: clock; all state updates occur on its rising edge.
REQ-004 Port rst_b, input, 1 bit: asynchronous active-low reset.
REQ-005 Ports req0 and req1, input, 1 bit each: job request per requester; held high until the matching grant.
REQ-006 Ports cmd0 and cmd1, input, 8 bits each: four input symbols; symbol k = {a,b} = cmd[2k+1:2k]; symbol 0 is issued first.
REQ-007 Ports len0 and len1, input, 2 bits each: number of symbols minus 1 (0 means 1 symbol, 3 means 4 symbols).
REQ-008 Ports gnt0 and gnt1, output, 1 bit each: one-cycle grant pulse; cmd and len are captured in that cycle.
REQ-009 Ports fsm_a and fsm_b, output, 1 bit each: drive the shared Mealy FSM's a and b inputs.
REQ-010 Ports fsm_m and fsm_n, input, 1 bit each: the shared FSM's combinational Mealy outputs.
REQ-011 Port fsm_rst_b, output, 1 bit: active-low reset to the shared FSM.
REQ-012 Port res, output, 8 bits: captured {m,n} per symbol, with {m,n} of symbol k at res[2k+1:2k]; unused pairs are 0.
REQ-013 Port res_id, output, 1 bit: the requester that owns res.
REQ-014 Port done, output, 1 bit: one-cycle pulse marking res and res_id as newly valid.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The controller SHALL have four one-cold encoded states: IDLE=4'b0111, CLEAR=4'b1011, RUN=4'b1101, DONE=4'b1110.
REQ-017 In IDLE, if any req is high, the block SHALL pulse exactly one gnt, latch that requester's cmd, len and id, and go to CLEAR.
REQ-018 Arbitration SHALL be round-robin:
- after reset, req0 has priority;
- after serving requester i, the other requester has priority;
- a lone request is always granted.
REQ-019 Requests outside IDLE SHALL NOT be granted, including in DONE; they wait until the next IDLE cycle.
REQ-020 CLEAR SHALL last CLR_CYCLES cycles with fsm_rst_b=0 and fsm_a=fsm_b=0, then go to RUN.
REQ-021 RUN SHALL last len+1 cycles.
- In cycle k, {fsm_a,fsm_b} = symbol k.
- {fsm_m,fsm_n} SHALL be sampled at the closing clock edge into internal result bit pair k.
REQ-022 After the last RUN cycle the block SHALL enter DONE for one cycle.
- In DONE, done=1, and res and res_id SHALL show the new job.
- The next state is IDLE.
REQ-023 res and res_id SHALL hold their value from DONE until the next DONE.
REQ-024 In IDLE, RUN and DONE, fsm_rst_b SHALL be 1.
REQ-025 In IDLE and DONE, fsm_a and fsm_b SHALL be 0.
REQ-026 Latency SHALL be fixed: gnt in cycle T, done in cycle T+1+CLR_CYCLES+(len+1).
REQ-027 A requester may change cmd and len after its gnt cycle without affecting the running job.
REQ-028 The maximum throughput SHALL be one job per 3+CLR_CYCLES+len cycles; there SHALL be no back-to-back grant.

Reset
REQ-029 While rst_b=0, the block SHALL be in IDLE with these output values:
- gnt0=gnt1=0, done=0, busy=0;
- fsm_a=fsm_b=0, fsm_rst_b=0;
- res=8'h00, res_id=0;
- round-robin priority on req0.
REQ-030 Reset during CLEAR, RUN or DONE SHALL abort the job immediately: no done pulse, res is cleared to 0, and no grant occurs in the first cycle after release.
REQ-031 After rst_b rises, fsm_rst_b SHALL go to 1 on the first clock edge.

Verification
REQ-032 Single 4-symbol job: req0=1, cmd0=8'h8F, len0=3, CLR_CYCLES=1 -> gnt0 at T; fsm a/b sequence 11,11,00,10; done at T+6 with res=8'hBE, res_id=0.
REQ-033 Single 1-symbol job: req1=1, cmd1=8'h02, len1=0 -> done at T+3 with res=8'h01, res_id=1.
REQ-034 Contention: req0 and req1 both held from reset release -> gnt0 first, then gnt1 in the first IDLE cycle after that job's done; a third job with both requests held grants req0.
REQ-035 Request while busy: raise req1 during RUN of job 0 -> gnt1 stays 0 until the IDLE cycle after done; the DONE cycle shows gnt1=0.
REQ-036 Independence: run the REQ-032 job twice with a different job between them -> both runs give res=8'hBE, since each job starts from a cleared FSM.
REQ-037 Reset mid-RUN: assert rst_b=0 in RUN cycle 1 of the REQ-032 job -> busy=0, fsm_rst_b=0, res=8'h00 immediately; no done; after release a new req0 completes normally.
